// File: rtl/haze_removal_engine_if.sv
// AXI4-Stream pixel link used on both sides of haze_removal_engine.
interface haze_removal_engine_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/haze_removal_engine.sv
// Dark-channel-prior dehazer: pass 1 estimates atmospheric light A, pass 2 outputs recovered J.
// Optional HAZE_DEBUG_T_EN: M_AXIS tdata[31:24] carries the clamped transmission t.
module haze_removal_engine #(
    parameter int unsigned FRAME_PIXELS = 262144,
    parameter int unsigned OMEGA        = 243,
    parameter int unsigned T0           = 26
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          enable,
    haze_removal_engine_if.slave          S_AXIS,
    haze_removal_engine_if.master         M_AXIS
);

    localparam int unsigned     CNT_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [7:0]      OMEGA_Q  = 8'(OMEGA);
    localparam logic [7:0]      T0_Q     = 8'(T0);

    typedef enum logic {ST_ALE = 1'b0, ST_TE = 1'b1} state_t;

    function automatic logic [7:0] f_min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // min(255, I*255 / max(A,1))
    function automatic logic [7:0] f_norm(input logic [7:0] i, input logic [7:0] a);
        logic [15:0] num;
        logic [15:0] den;
        logic [15:0] q;
        num = 16'(i) * 16'd255;
        den = (a == 8'd0) ? 16'd1 : 16'(a);
        q   = num / den;
        return (q > 16'd255) ? 8'd255 : q[7:0];
    endfunction

    function automatic logic signed [17:0] f_quo(input logic [7:0] i, input logic [7:0] a, input logic [7:0] t);
        logic signed [17:0] num;
        num = ($signed({10'd0, i}) - $signed({10'd0, a})) * 18'sd256;
        return num / $signed({10'd0, t});
    endfunction

    function automatic logic [7:0] f_recover(input logic [7:0] a, input logic signed [17:0] q);
        logic signed [18:0] s;
        s = $signed({11'd0, a}) + 19'(q);
        if (s < 19'sd0)        return 8'd0;
        else if (s > 19'sd255) return 8'd255;
        else                   return s[7:0];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_s_tready;
    logic               w_acc_ale;
    logic               w_acc_te;
    logic               w_acc;
    logic               w_adv;
    logic               w_eof;
    logic [7:0]         w_d_in;

    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_a_r, r_a_g, r_a_b;
    logic [7:0]         r_dmax;
    logic               r_first;

    logic               r_s1_vld, r_s1_last;
    logic [23:0]        r_s1_pix, r_s1_a, r_s1_q;
    logic               r_s2_vld, r_s2_last;
    logic [23:0]        r_s2_pix, r_s2_a;
    logic [7:0]         r_s2_t;
    logic               r_s3_vld, r_s3_last;
    logic [23:0]        r_s3_a;
    logic signed [17:0] r_s3_qr, r_s3_qg, r_s3_qb;
    logic               r_s4_vld, r_s4_last;
    logic [23:0]        r_s4_j;
`ifdef HAZE_DEBUG_T_EN
    logic [7:0]         r_s3_t, r_s4_t;
`endif
    logic               r_m_vld, r_m_last;
    logic [31:0]        r_m_data;

    logic [7:0]         w_dn;
    logic [15:0]        w_prod;
    logic [7:0]         w_traw;
    logic [7:0]         w_t;
    logic               w_unused_hi;

    assign w_adv  = !r_m_vld || M_AXIS.tready;
    assign w_eof  = (r_cnt == CNT_LAST) || S_AXIS.tlast;
    assign w_acc  = w_acc_ale || w_acc_te;
    assign w_d_in = f_min3(S_AXIS.tdata[23:16], S_AXIS.tdata[15:8], S_AXIS.tdata[7:0]);
    assign w_unused_hi = &{1'b0, S_AXIS.tdata[31:24]};

    // Transmission from the normalized dark channel
    assign w_dn   = f_min3(r_s1_q[23:16], r_s1_q[15:8], r_s1_q[7:0]);
    assign w_prod = 16'(OMEGA_Q) * 16'(w_dn);
    assign w_traw = 8'd255 - w_prod[15:8];
    assign w_t    = (w_traw < T0_Q) ? T0_Q : w_traw;

    always_ff @(posedge ACLK) begin
        if (ARESET)      r_state <= ST_ALE;
        else if (enable) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ALE:  if (w_acc && w_eof) w_state_nxt = ST_TE;
            ST_TE:   if (w_acc && w_eof) w_state_nxt = ST_ALE;
            default: w_state_nxt = ST_ALE;
        endcase
    end

    always_comb begin
        w_s_tready = 1'b0;
        w_acc_ale  = 1'b0;
        w_acc_te   = 1'b0;
        case (r_state)
            ST_ALE: begin
                w_s_tready = enable;
                w_acc_ale  = S_AXIS.tvalid && enable;
            end
            ST_TE: begin
                w_s_tready = enable && w_adv;
                w_acc_te   = S_AXIS.tvalid && enable && w_adv;
            end
            default: ;
        endcase
    end

    // Pixel counter and atmospheric-light estimate
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cnt   <= '0;
            r_a_r   <= 8'd255;
            r_a_g   <= 8'd255;
            r_a_b   <= 8'd255;
            r_dmax  <= 8'd0;
            r_first <= 1'b1;
        end else if (w_acc) begin
            r_cnt <= w_eof ? '0 : r_cnt + CNT_W'(1);
            if (w_acc_ale) begin
                r_first <= 1'b0;
                if (r_first || (w_d_in > r_dmax)) begin
                    r_a_r  <= S_AXIS.tdata[23:16];
                    r_a_g  <= S_AXIS.tdata[15:8];
                    r_a_b  <= S_AXIS.tdata[7:0];
                    r_dmax <= w_d_in;
                end
            end
            if (w_acc_te && w_eof) begin
                r_first <= 1'b1;
                r_dmax  <= 8'd0;
            end
        end
    end

    // A travels with each pixel so draining pass-2 pixels are immune to the next pass-1 update
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_s3_vld <= 1'b0;
            r_s4_vld <= 1'b0;
            r_m_vld  <= 1'b0;
            r_m_last <= 1'b0;
            r_m_data <= 32'd0;
        end else if (enable && w_adv) begin
            r_s1_vld  <= w_acc_te;
            r_s1_last <= w_acc_te && w_eof;
            r_s1_pix  <= S_AXIS.tdata[23:0];
            r_s1_a    <= {r_a_r, r_a_g, r_a_b};
            r_s1_q    <= {f_norm(S_AXIS.tdata[23:16], r_a_r),
                          f_norm(S_AXIS.tdata[15:8],  r_a_g),
                          f_norm(S_AXIS.tdata[7:0],   r_a_b)};

            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
            r_s2_pix  <= r_s1_pix;
            r_s2_a    <= r_s1_a;
            r_s2_t    <= w_t;

            r_s3_vld  <= r_s2_vld;
            r_s3_last <= r_s2_last;
            r_s3_a    <= r_s2_a;
            r_s3_qr   <= f_quo(r_s2_pix[23:16], r_s2_a[23:16], r_s2_t);
            r_s3_qg   <= f_quo(r_s2_pix[15:8],  r_s2_a[15:8],  r_s2_t);
            r_s3_qb   <= f_quo(r_s2_pix[7:0],   r_s2_a[7:0],   r_s2_t);

            r_s4_vld  <= r_s3_vld;
            r_s4_last <= r_s3_last;
            r_s4_j    <= {f_recover(r_s3_a[23:16], r_s3_qr),
                          f_recover(r_s3_a[15:8],  r_s3_qg),
                          f_recover(r_s3_a[7:0],   r_s3_qb)};
`ifdef HAZE_DEBUG_T_EN
            r_s3_t    <= r_s2_t;
            r_s4_t    <= r_s3_t;
`endif

            r_m_vld  <= r_s4_vld;
            r_m_last <= r_s4_vld && r_s4_last;
            if (r_s4_vld) begin
`ifdef HAZE_DEBUG_T_EN
                r_m_data <= {r_s4_t, r_s4_j};
`else
                r_m_data <= {8'd0, r_s4_j};
`endif
            end
        end
    end

    assign S_AXIS.tready = w_s_tready;
    assign M_AXIS.tdata  = r_m_data;
    assign M_AXIS.tvalid = r_m_vld;
    assign M_AXIS.tlast  = r_m_last;

endmodule

// File: tb/tb_haze_removal_engine.sv
// Scoreboard bench for haze_removal_engine: reference model predicts each recovered pixel.
module tb_haze_removal_engine;
    localparam int unsigned FP    = 4;
    localparam int          OMEGA = 243;
    localparam int          T0    = 26;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    logic en   = 1'b1;
    always #5 clk = ~clk;

    haze_removal_engine_if s_if();
    haze_removal_engine_if m_if();

    logic rdy_rnd_en = 1'b0;
    logic rdy_fix    = 1'b1;
    logic rdy_rnd    = 1'b1;
    assign m_if.tready = rdy_rnd_en ? rdy_rnd : rdy_fix;
    always @(posedge clk) rdy_rnd <= ($urandom_range(0, 3) != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    haze_removal_engine #(.FRAME_PIXELS(FP), .OMEGA(OMEGA), .T0(T0)) dut (
        .ACLK   (clk),
        .ARESET (arst),
        .enable (en),
        .S_AXIS (s_if),
        .M_AXIS (m_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0] exp_q[$];
    logic [23:0] p1_q[$];
    logic        m_pass2 = 1'b0;
    int          p2_cnt  = 0;
    logic [23:0] ma      = 24'hFFFFFF;
    logic        lat_req = 1'b0;
    logic        lat_armed = 1'b0;
    int          acc_cyc = 0;

    logic [23:0] p1_dir [4] = '{24'h1E140A, 24'hC8C8C8, 24'h463C32, 24'hC8C8C8};
    logic [23:0] p2_dir [4] = '{24'hC8C8C8, 24'h646464, 24'h1E140A, 24'hC8C8C8};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dark(input logic [23:0] px);
        int m;
        m = int'(px[23:16]);
        if (int'(px[15:8]) < m) m = int'(px[15:8]);
        if (int'(px[7:0]) < m)  m = int'(px[7:0]);
        return m;
    endfunction

    // Recovered pixel straight from the dehazing formulas, integer math
    function automatic logic [31:0] ref_j(input logic [23:0] px, input logic [23:0] a);
        int i_c [3];
        int a_c [3];
        int q, dn, t, j;
        logic [23:0] o;
        dn = 255;
        o  = '0;
        for (int c = 0; c < 3; c++) begin
            i_c[c] = int'(px[8*c +: 8]);
            a_c[c] = int'(a[8*c +: 8]);
            q = (i_c[c] * 255) / ((a_c[c] < 1) ? 1 : a_c[c]);
            if (q > 255) q = 255;
            if (q < dn)  dn = q;
        end
        t = 255 - (OMEGA * dn) / 256;
        if (t < T0) t = T0;
        for (int c = 0; c < 3; c++) begin
            j = a_c[c] + ((i_c[c] - a_c[c]) * 256) / t;
            if (j < 0)   j = 0;
            if (j > 255) j = 255;
            o[8*c +: 8] = 8'(j);
        end
        return {8'h00, o};
    endfunction

    function automatic void model_accept(input logic [23:0] px, input logic last);
        logic [23:0] best;
        logic        eof;
        if (!m_pass2) begin
            p1_q.push_back(px);
            if (p1_q.size() == int'(FP) || last) begin
                best = p1_q[0];
                for (int i = 1; i < p1_q.size(); i++)
                    if (dark(p1_q[i]) > dark(best)) best = p1_q[i];
                ma = best;
                p1_q.delete();
                m_pass2 = 1'b1;
            end
        end else begin
            if (lat_req) begin
                acc_cyc   = cyc + 1;
                lat_req   = 1'b0;
                lat_armed = 1'b1;
            end
            p2_cnt++;
            eof = (p2_cnt == int'(FP)) || last;
            exp_q.push_back({eof, ref_j(px, ma)});
            if (eof) begin
                m_pass2 = 1'b0;
                p2_cnt  = 0;
            end
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        p1_q.delete();
        m_pass2 = 1'b0;
        p2_cnt  = 0;
        ma      = 24'hFFFFFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [23:0] px, input logic last);
        bit done;
        done = 1'b0;
        s_if.tdata  = {8'($urandom), px};
        s_if.tvalid = 1'b1;
        s_if.tlast  = last;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (s_if.tready) begin
                model_accept(px, last);
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no tready expected tready within 300 cycles");
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic en_window(input logic [23:0] px);
        en = 1'b0;
        rdy_fix = 1'b0;
        s_if.tdata  = {8'h00, px};
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en_low_tready", 32'(s_if.tready), 32'd0);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        rdy_fix = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        tick(1);
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks stall stability
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [32:0] e;
    always @(negedge clk) begin
        if (arst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tvalid", 32'(m_if.tvalid), 32'd1);
                check("stall_tdata", m_if.tdata, prev_data);
            end
            if (lat_armed && m_if.tvalid) begin
                check("first_latency", 32'(cyc - acc_cyc), 32'd4);
                lat_armed = 1'b0;
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %h expected no output", m_if.tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_tdata", m_if.tdata, e[31:0]);
                    check("out_tlast", 32'(m_if.tlast), 32'(e[32]));
                end
            end
            prev_stall <= m_if.tvalid && !m_if.tready;
            prev_data  <= m_if.tdata;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;

        // 1: reset
        arst = 1'b1;
        en   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tlast",  32'(m_if.tlast),  32'd0);
        check("rst_tdata",  m_if.tdata,       32'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", 32'(s_if.tready), 32'd1);
        tick(1);

        // 2 and 3: directed pass 1 then pass 2, latency on the first output
        for (int i = 0; i < 4; i++) send(p1_dir[i], 1'b0);
        tick(6);
        @(negedge clk);
        check("pass1_no_tvalid", 32'(m_if.tvalid), 32'd0);
        tick(1);
        lat_req = 1'b1;
        for (int i = 0; i < 4; i++) send(p2_dir[i], 1'b0);
        wait_drain();

        // 4: downstream stall in the middle of pass 2
        for (int i = 0; i < 4; i++) send(p1_dir[i], 1'b0);
        send(p2_dir[0], 1'b0);
        rdy_fix = 1'b0;
        send(p2_dir[1], 1'b0);
        send(p2_dir[2], 1'b0);
        tick(3);
        @(negedge clk);
        check("stall_out_valid", 32'(m_if.tvalid), 32'd1);
        check("stall_in_tready", 32'(s_if.tready), 32'd0);
        fork
            begin
                tick(3);
                rdy_fix = 1'b1;
            end
            begin
                tick(1);
                send(p2_dir[3], 1'b0);
            end
        join
        wait_drain();

        // 5: enable dropped once in each pass
        send(p1_dir[0], 1'b0);
        en_window(p1_dir[1]);
        for (int i = 1; i < 4; i++) send(p1_dir[i], 1'b0);
        send(p2_dir[0], 1'b0);
        send(p2_dir[1], 1'b0);
        en_window(p2_dir[2]);
        send(p2_dir[2], 1'b0);
        send(p2_dir[3], 1'b0);
        wait_drain();

        // 6: reset after two pass-2 inputs
        for (int i = 0; i < 4; i++) send(24'($urandom), 1'b0);
        send(24'($urandom), 1'b0);
        send(24'($urandom), 1'b0);
        arst = 1'b1;
        model_reset();
        tick(2);
        arst = 1'b0;
        @(negedge clk);
        check("rst_mid_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_mid_tdata",  m_if.tdata,       32'd0);
        tick(8);
        for (int i = 0; i < 8; i++) send(24'($urandom), 1'b0);
        wait_drain();

        // Randomized stream: random pixels, early TLAST, gaps and backpressure
        rdy_rnd_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int g;
            send(24'($urandom), ($urandom_range(0, 5) == 0));
            g = int'($urandom_range(0, 2));
            if (g > 0) tick(g);
        end
        rdy_rnd_en = 1'b0;
        rdy_fix    = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
